// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, function-key codes and the key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  localparam logic [2:0] FUNC_0 = 3'd0;
  localparam logic [2:0] FUNC_1 = 3'd1;
  localparam logic [2:0] FUNC_2 = 3'd2;
  localparam logic [2:0] FUNC_3 = 3'd3;
  localparam logic [2:0] FUNC_4 = 3'd4;
  localparam logic [2:0] FUNC_5 = 3'd5;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] value;
  } key_t;

  // Indexed by {row, col}; element 15 is written first.
  localparam logic [15:0][4:0] KEY_MAP = {
    {2'b00, FUNC_3}, {2'b00, FUNC_5}, 5'h10,           {2'b00, FUNC_4},
    {2'b00, FUNC_2}, 5'h19,           5'h18,           5'h17,
    {2'b00, FUNC_1}, 5'h16,           5'h15,           5'h14,
    {2'b00, FUNC_0}, 5'h13,           5'h12,           5'h11
  };

  function automatic key_t key_lookup(input logic [1:0] r, input logic [1:0] c);
    return key_t'(KEY_MAP[{r, c}]);
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Tick-qualified saturating counter: clr wins, start loads 1, inc counts up to MAX.
module keypad_debounce_cnt #(
  parameter int MAX = 20,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         clr,
  input  logic         start,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (tick && start)
      count <= W'(1);
    else if (tick && inc && (count != W'(MAX)))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, digit/function decode and strobes.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe held digit keys every REPEAT_N ticks.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 20,
  parameter int REPEAT_N   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] func,
  output logic       funcPressed,
  output logic       keyDown
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       row_meta, row_sync;
  state_t           state;
  logic [3:0]       col_reg;
  logic [1:0]       col_idx, lat_row;
  logic [3:0]       num_reg;
  logic [2:0]       func_reg;
  logic             num_pressed_reg, func_pressed_reg, key_down_reg;
  logic             any_low, hit_low, deb_done;
  logic             db_clr, db_start, db_inc;
  logic [CNT_W-1:0] db_cnt;
  logic             rpt_fire;
  key_t             cur_key;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign any_low  = ~&row_sync;
  assign hit_low  = ~row_sync[lat_row];
  assign cur_key  = key_lookup(lat_row, col_idx);
  assign deb_done = (db_cnt >= CNT_W'(DEBOUNCE_N - 1));

  always_comb begin
    db_clr   = (state == ST_SCAN) && !any_low;
    db_start = ((state == ST_SCAN) && any_low) || ((state == ST_PRESSED) && !hit_low);
    db_inc   = ((state == ST_DEBOUNCE) && hit_low) || ((state == ST_RELEASE) && !hit_low);
  end

  keypad_debounce_cnt #(.MAX(DEBOUNCE_N), .W(CNT_W)) u_db_cnt (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clr   (db_clr),
    .start (db_start),
    .inc   (db_inc),
    .count (db_cnt)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_N + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_run;

  // Counts ticks while a digit key stays held; restarts after every repeat strobe.
  assign rpt_run  = (state == ST_PRESSED) && hit_low && cur_key.is_digit;
  assign rpt_fire = rpt_run && (rpt_cnt == RPT_W'(REPEAT_N - 1));

  keypad_debounce_cnt #(.MAX(REPEAT_N), .W(RPT_W)) u_rpt_cnt (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clr   (!rpt_run || (tick && rpt_fire)),
    .start (1'b0),
    .inc   (1'b1),
    .count (rpt_cnt)
  );
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_N != 0);
  assign rpt_fire      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_SCAN;
      col_reg          <= 4'b1110;
      col_idx          <= 2'd0;
      lat_row          <= 2'd0;
      num_reg          <= 4'd0;
      func_reg         <= 3'd0;
      num_pressed_reg  <= 1'b0;
      func_pressed_reg <= 1'b0;
      key_down_reg     <= 1'b0;
    end else begin
      num_pressed_reg  <= 1'b0;
      func_pressed_reg <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (any_low) begin
              lat_row <= lowest_low(row_sync);
              state   <= ST_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 1'b1;
              col_reg <= {col_reg[2:0], col_reg[3]};
            end
          end
          ST_DEBOUNCE: begin
            if (!hit_low) begin
              state <= ST_SCAN;
            end else if (deb_done) begin
              state        <= ST_PRESSED;
              key_down_reg <= 1'b1;
              if (cur_key.is_digit) begin
                num_reg         <= cur_key.value;
                num_pressed_reg <= 1'b1;
              end else begin
                func_reg         <= cur_key.value[2:0];
                func_pressed_reg <= 1'b1;
              end
            end
          end
          ST_PRESSED: begin
            if (!hit_low)
              state <= ST_RELEASE;
            else if (rpt_fire)
              num_pressed_reg <= 1'b1;
          end
          ST_RELEASE: begin
            if (hit_low) begin
              state <= ST_PRESSED;
            end else if (deb_done) begin
              state        <= ST_SCAN;
              key_down_reg <= 1'b0;
              col_idx      <= col_idx + 1'b1;
              col_reg      <= {col_reg[2:0], col_reg[3]};
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  assign col         = col_reg;
  assign num         = num_reg;
  assign func        = func_reg;
  assign numPressed  = num_pressed_reg;
  assign funcPressed = func_pressed_reg;
  assign keyDown     = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a matrix model drives row from col and a pressed-key mask.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, num;
  logic [2:0]  func;
  logic        numPressed, funcPressed, keyDown;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc;
  int np_total = 0, fp_total = 0;
  int np_run = 0, fp_run = 0, max_np_run = 0, max_fp_run = 0, overlap = 0;
  int np_base, fp_base, exp_rpt;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3), .REPEAT_N(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .num         (num),
    .numPressed  (numPressed),
    .func        (func),
    .funcPressed (funcPressed),
    .keyDown     (keyDown)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low whenever column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  // Posedge count since reset release; the DUT ticks on every 4th edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (numPressed) begin
      np_total <= np_total + 1;
      np_run   <= np_run + 1;
      if (np_run + 1 > max_np_run) max_np_run <= np_run + 1;
    end else np_run <= 0;
    if (funcPressed) begin
      fp_total <= fp_total + 1;
      fp_run   <= fp_run + 1;
      if (fp_run + 1 > max_fp_run) max_fp_run <= fp_run + 1;
    end else fp_run <= 0;
    if (numPressed && funcPressed) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tick();
    do step(1); while (cyc % 4 != 0);
  endtask

  task automatic wait_key(input string tag, input logic lvl);
    int n;
    n = 0;
    while (keyDown !== lvl && n < 300) begin
      step(1);
      n++;
    end
    check(tag, keyDown, lvl);
  endtask

  task automatic align_col(input string tag, input logic [3:0] want);
    int n;
    n = 0;
    do begin
      wait_tick();
      n++;
    end while (col !== want && n < 8);
    check(tag, col, want);
  endtask

  initial begin
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_num", num, 0);
    check("rst_func", func, 0);
    check("rst_np", numPressed, 0);
    check("rst_fp", funcPressed, 0);
    check("rst_kd", keyDown, 0);
    reset = 1'b1;

    // Key (1,1) -> digit 5, then a timed release.
    np_base = np_total; fp_base = fp_total;
    wait_tick();
    keys[5] = 1'b1;
    wait_key("k11_down", 1'b1);
    check("k11_np", np_total - np_base, 1);
    check("k11_num", num, 5);
    check("k11_col", col, 4'b1101);
    check("k11_fp", fp_total - fp_base, 0);
    wait_tick();
    keys = '0;
    step(11);
    check("k11_rel_hold", keyDown, 1);
    step(1);
    check("k11_rel_done", keyDown, 0);

    // Key (2,3) -> func 2, digit outputs untouched.
    np_base = np_total; fp_base = fp_total;
    keys[11] = 1'b1;
    wait_key("k23_down", 1'b1);
    check("k23_fp", fp_total - fp_base, 1);
    check("k23_func", func, 2);
    check("k23_np", np_total - np_base, 0);
    check("k23_num", num, 5);
    keys = '0;
    wait_key("k23_up", 1'b0);

    // Key (3,1) with a low/high bounce before settling -> digit 0 once.
    align_col("k31_align", 4'b1101);
    np_base = np_total;
    keys[13] = 1'b1;
    step(4);
    keys[13] = 1'b0;
    step(4);
    check("k31_bounce_np", np_total - np_base, 0);
    keys[13] = 1'b1;
    wait_key("k31_down", 1'b1);
    check("k31_np", np_total - np_base, 1);
    check("k31_num", num, 0);
    keys = '0;
    wait_key("k31_up", 1'b0);

    // Keys (1,2) and (2,2) together -> lowest row wins, digit 6.
    np_base = np_total;
    keys[6] = 1'b1; keys[10] = 1'b1;
    wait_key("k12_down", 1'b1);
    check("k12_np", np_total - np_base, 1);
    check("k12_num", num, 6);
    keys = '0;
    wait_key("k12_up", 1'b0);

    // Hold (0,0), press (1,1) meanwhile, then a one-tick release glitch.
    np_base = np_total;
    keys[0] = 1'b1;
    wait_key("k00_down", 1'b1);
    keys[5] = 1'b1;
    step(12);
    check("k00_np", np_total - np_base, 1);
    check("k00_num", num, 1);
    keys[5] = 1'b0;
    wait_tick();
    keys[0] = 1'b0;
    step(4);
    keys[0] = 1'b1;
    step(12);
    check("k00_glitch_kd", keyDown, 1);
    check("k00_glitch_np", np_total - np_base, 1);
    keys = '0;
    wait_key("k00_up", 1'b0);

    // Reset during debounce of (0,2); key stays held and must re-debounce fully.
    align_col("k02_align", 4'b1011);
    keys[2] = 1'b1;
    step(5);
    reset = 1'b0;
    #1;
    check("k02_rst_col", col, 4'b1110);
    check("k02_rst_kd", keyDown, 0);
    check("k02_rst_num", num, 0);
    check("k02_rst_func", func, 0);
    check("k02_rst_np", numPressed, 0);
    step(2);
    reset = 1'b1;
    np_base = np_total;
    step(19);
    check("k02_early_kd", keyDown, 0);
    check("k02_early_np", np_total - np_base, 0);
    step(1);
    check("k02_kd", keyDown, 1);
    check("k02_np", np_total - np_base, 1);
    check("k02_num", num, 3);
    keys = '0;
    wait_key("k02_up", 1'b0);

    // Hold (0,1) for 12 ticks after acceptance.
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_rpt = 3;
`else
    exp_rpt = 1;
`endif
    np_base = np_total;
    keys[1] = 1'b1;
    wait_key("k01_down", 1'b1);
    step(48);
    check("k01_np", np_total - np_base, exp_rpt);
    check("k01_num", num, 2);
    keys = '0;
    wait_key("k01_up", 1'b0);

    check("np_width", max_np_run, 1);
    check("fp_width", max_fp_run, 1);
    check("strobe_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (1 kHz at 50 MHz).
REQ-002 Parameter DEBOUNCE_N, default 20, consecutive stable scan ticks to accept a press or a release.
REQ-003 Parameter REPEAT_N, default 500, scan ticks between auto-repeat strobes (used only under KEYPAD_AUTOREPEAT_EN).
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 row  in  4  keypad row sense, active-low, externally pulled up.
REQ-007 col  out  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-008 num  out  4  last accepted digit value 0-9; held until the next digit.
REQ-009 numPressed  out  1  one-clk strobe on each accepted digit key; drives the digit-entry register's numPressed input.
REQ-010 func  out  3  last accepted function-key code 0-5; held until the next function key.
REQ-011 funcPressed  out  1  one-clk strobe on each accepted function key.
REQ-012 keyDown  out  1  high from press acceptance until release acceptance.

Function
REQ-013 row shall pass through a 2-flop synchronizer before any use; a free-running counter shall emit a one-clk tick every SCAN_DIV clks, wrapping SCAN_DIV-1 -> 0.
REQ-014 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE; all transitions evaluated only on tick.
REQ-015 SCAN: no synchronized row low -> advance active column 0->1->2->3->0; any row low -> latch column index and lowest-index low row, debounce count = 1, go DEBOUNCE with column frozen.
REQ-016 DEBOUNCE: latched row still low -> count+1; count reaches DEBOUNCE_N -> go PRESSED and emit exactly one strobe in the next clk; latched row high -> go SCAN with no strobe.
REQ-017 Key mapping (row,col): rows 0-2 / cols 0-2 -> digits 1-9 row-major, (3,1) -> digit 0; (0,3),(1,3),(2,3),(3,3),(3,0),(3,2) -> func 0-5 in that order.
REQ-018 Digit accept -> num updated and numPressed high for exactly one clk; function accept -> func updated and funcPressed high for exactly one clk; the two strobes shall never be high together.
REQ-019 PRESSED: column frozen; any other key pressed meanwhile is ignored; latched row high -> go RELEASE with count = 1.
REQ-020 RELEASE: latched row high for DEBOUNCE_N consecutive ticks -> keyDown low, go SCAN, advance column; latched row low on any tick -> back to PRESSED with no new strobe.
REQ-021 Multiple rows low in the same column at detection: lowest row index wins; keys in other columns are not seen until the scan reaches them.

Reset
REQ-022 reset low shall asynchronously force: state SCAN, col = 4'b1110, num = 0, func = 0, numPressed = 0, funcPressed = 0, keyDown = 0, all counters and synchronizer flops = 0.
REQ-023 reset asserted mid-debounce or mid-press shall discard that key; no strobe is emitted after reset release until a fresh full debounce completes.

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN defined: in PRESSED, a digit key held for REPEAT_N ticks re-emits numPressed, then again every REPEAT_N ticks; function keys never repeat.
REQ-025 KEYPAD_AUTOREPEAT_EN undefined: exactly one strobe per physical press; the repeat counter is not synthesized.

Structure
REQ-026 Package keypad_pkg shall hold the FSM state encoding, func code constants (6 codes) and the 16-entry key map table.
REQ-027 One sub-module, keypad_debounce_cnt (tick-qualified saturating counter with clear), is instantiated for the DEBOUNCE/RELEASE count and, under the macro, the repeat count.

Verification
REQ-028 Bench, with SCAN_DIV=4 and DEBOUNCE_N=3: press (1,1) stably -> numPressed one clk, num=5, keyDown=1; release -> keyDown=0 after 3 ticks.
REQ-029 Press (3,1) with a 2-tick bounce (low,high,low) then stable low -> exactly one numPressed with num=0, no strobe during the bounce.
REQ-030 Press (2,3) -> funcPressed one clk with func=2, numPressed stays 0, num unchanged.
REQ-031 Hold (0,0) and press (1,1) during PRESSED -> only num=1 strobed; release glitch of 1 tick -> no second strobe.
REQ-032 reset low during DEBOUNCE of (0,2) -> outputs at reset values, col=4'b1110, no numPressed.
REQ-033 With KEYPAD_AUTOREPEAT_EN, REPEAT_N=5: hold (0,1) for 12 ticks past acceptance -> three numPressed strobes total, num=2.
